// File: rtl/pc_gen_if.sv
// Bus between the decode/branch-resolve stage and the fetch PC generator.
// The master drives the resolved control flow; the slave returns the fetch PC and RAS status.
interface pc_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic             pc_wen;
    logic             branch;
    logic             bne;
    logic             zflag;
    logic [WIDTH-1:0] bmemaddr;
    logic [31:0]      bmemload;
    logic             jump;
    logic             jal;
    logic             jr;
    logic             jr_ra;
    logic [WIDTH-1:0] jaddr;
    logic [WIDTH-1:0] imemaddr;
    logic             redirect;
    logic             ras_hit;
    logic             ras_empty;
    logic             ras_full;

    modport master (
        output pc_wen, branch, bne, zflag, bmemaddr, bmemload,
        output jump, jal, jr, jr_ra, jaddr,
        input  imemaddr, redirect, ras_hit, ras_empty, ras_full
    );

    modport slave (
        input  pc_wen, branch, bne, zflag, bmemaddr, bmemload,
        input  jump, jal, jr, jr_ra, jaddr,
        output imemaddr, redirect, ras_hit, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, prioritised branch/jump/jr redirects and a
// circular return-address stack fed by jal and drained by jr $ra.
module pc_gen #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] PC_INIT   = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] imemaddr_q, imemaddr_d;
    logic             redirect_q, redirect_d;
    logic             ras_hit_q, ras_hit_d;
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             taken, push, pop, ras_empty, ras_full;
    logic [WIDTH-1:0] br_tgt, j_tgt, jr_tgt, ras_top, ret_addr;
    logic [PtrW-1:0]  top_idx;

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CntW'(RAS_DEPTH));

    // ptr_q is the next free slot, so the top of stack sits one below it.
    assign top_idx  = ptr_q - PtrW'(1);
    assign ras_top  = ras_q[top_idx];
    assign ret_addr = bus.bmemaddr + WIDTH'(4);

    assign taken  = (bus.branch & bus.zflag) | (bus.bne & ~bus.zflag);
    assign br_tgt = ret_addr + ({{(WIDTH-16){bus.bmemload[15]}}, bus.bmemload[15:0]} << 2);
    assign j_tgt  = {bus.bmemaddr[WIDTH-1:28], bus.bmemload[25:0], 2'b00};
    assign jr_tgt = (bus.jr_ra && !ras_empty) ? ras_top : bus.jaddr;

    always_comb begin
        imemaddr_d = imemaddr_q;
        redirect_d = 1'b0;
        ras_hit_d  = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        if (taken) begin
            imemaddr_d = br_tgt;
            redirect_d = 1'b1;
        end else if (bus.jump) begin
            imemaddr_d = j_tgt;
            redirect_d = 1'b1;
            push       = bus.jal;
        end else if (bus.jr) begin
            imemaddr_d = jr_tgt;
            redirect_d = 1'b1;
            if (bus.jr_ra && !ras_empty) begin
                pop       = 1'b1;
                ras_hit_d = (ras_top == bus.jaddr);
            end
        end else if (bus.pc_wen) begin
            imemaddr_d = imemaddr_q + WIDTH'(4);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + PtrW'(1);
            cnt_d = ras_full ? cnt_q : cnt_q + CntW'(1);
        end else if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imemaddr_q <= PC_INIT;
            redirect_q <= 1'b0;
            ras_hit_q  <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            imemaddr_q <= imemaddr_d;
            redirect_q <= redirect_d;
            ras_hit_q  <= ras_hit_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Entries need no reset; a full push simply overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            ras_q[ptr_q] <= ret_addr;
        end
    end

    assign bus.imemaddr  = imemaddr_q;
    assign bus.redirect  = redirect_q;
    assign bus.ras_hit   = ras_hit_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, sequential fetch, branches, jumps, RAS push/pop/wrap,
// redirect priority and reset-over-redirect.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    pc_gen_if #(.WIDTH(32)) bus ();

    pc_gen #(
        .WIDTH    (32),
        .PC_INIT  (32'h200),
        .RAS_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.pc_wen = 0; bus.branch = 0; bus.bne = 0; bus.zflag = 0;
        bus.bmemaddr = '0; bus.bmemload = '0; bus.jump = 0; bus.jal = 0;
        bus.jr = 0; bus.jr_ra = 0; bus.jaddr = '0;
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp_pc, input logic exp_rd);
        total++;
        if (bus.imemaddr !== exp_pc) begin
            $display("FAIL %s imemaddr got=%h exp=%h", name, bus.imemaddr, exp_pc);
            bad++;
        end
        total++;
        if (bus.redirect !== exp_rd) begin
            $display("FAIL %s redirect got=%b exp=%b", name, bus.redirect, exp_rd);
            bad++;
        end
    endtask

    task automatic chk_ras(input string name, input logic exp_hit, input logic exp_empty,
                           input logic exp_full);
        total++;
        if ({bus.ras_hit, bus.ras_empty, bus.ras_full} !== {exp_hit, exp_empty, exp_full}) begin
            $display("FAIL %s hit/empty/full got=%b%b%b exp=%b%b%b", name, bus.ras_hit,
                     bus.ras_empty, bus.ras_full, exp_hit, exp_empty, exp_full);
            bad++;
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        step();
        step();
        rst = 0;
        chk_pc("reset", 32'h200, 1'b0);
        chk_ras("reset_ras", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc = 32'h200;
        idle();
        bus.pc_wen = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_pc += 4;
            chk_pc("seq", exp_pc, 1'b0);
        end
    endtask

    task automatic test_branch();
        idle();
        bus.pc_wen = 1; bus.branch = 1; bus.zflag = 1;
        bus.bmemaddr = 32'h100; bus.bmemload = 32'h0000_FFFF;
        step();
        chk_pc("beq_neg", 32'h100, 1'b1);
        idle();
        bus.pc_wen = 1; bus.bne = 1; bus.zflag = 1;
        step();
        chk_pc("bne_not_taken_adv", 32'h104, 1'b0);
        bus.pc_wen = 0;
        step();
        chk_pc("bne_not_taken_hold", 32'h104, 1'b0);
        idle();
        bus.branch = 1; bus.zflag = 1; bus.bmemaddr = 32'h1000; bus.bmemload = 32'h10;
        step();
        chk_pc("beq_pos_stall", 32'h1044, 1'b1);
        idle();
        bus.bne = 1; bus.zflag = 0; bus.bmemaddr = 32'h2000; bus.bmemload = 32'h8000;
        step();
        chk_pc("bne_min_off", 32'hFFFE_2004, 1'b1);
    endtask

    task automatic test_jump();
        idle();
        bus.jump = 1; bus.bmemaddr = 32'h4000_0010; bus.bmemload = 32'h40;
        step();
        chk_pc("jump_stall", 32'h4000_0100, 1'b1);
        idle();
        step();
        chk_pc("hold_after_jump", 32'h4000_0100, 1'b0);
        chk_ras("jump_no_push", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ras();
        logic [31:0] exp_pop [4] = '{32'h54, 32'h44, 32'h34, 32'h24};
        for (int i = 1; i <= 5; i++) begin
            idle();
            bus.jump = 1; bus.jal = 1; bus.bmemaddr = 32'h10 * i;
            step();
            chk_pc("jal", 32'h0, 1'b1);
            chk_ras("jal_ras", 1'b0, 1'b0, i >= 4);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            bus.jr = 1; bus.jr_ra = 1;
            bus.jaddr = (i == 1) ? 32'h999 : exp_pop[i];
            step();
            chk_pc("jr_ra_pop", exp_pop[i], 1'b1);
            chk_ras("jr_ra_ras", i != 1, i == 3, 1'b0);
        end
    endtask

    task automatic test_jr_empty();
        idle();
        bus.jr = 1; bus.jr_ra = 1; bus.jaddr = 32'h80;
        step();
        chk_pc("jr_empty", 32'h80, 1'b1);
        chk_ras("jr_empty_ras", 1'b0, 1'b1, 1'b0);
        idle();
        bus.pc_wen = 1;
        step();
        chk_pc("after_jr_empty", 32'h84, 1'b0);
    endtask

    task automatic test_priority();
        idle();
        bus.branch = 1; bus.zflag = 1; bus.jump = 1; bus.jal = 1;
        bus.bmemaddr = 32'h300; bus.bmemload = 32'h1;
        step();
        chk_pc("br_over_jal", 32'h308, 1'b1);
        chk_ras("br_over_jal_ras", 1'b0, 1'b1, 1'b0);
        idle();
        bus.jump = 1; bus.jal = 1; bus.bmemaddr = 32'h600; bus.bmemload = 32'h100;
        step();
        chk_pc("jal_push", 32'h400, 1'b1);
        idle();
        bus.jump = 1; bus.bmemaddr = 32'h700; bus.bmemload = 32'h200;
        bus.jr = 1; bus.jr_ra = 1; bus.jaddr = 32'h604;
        step();
        chk_pc("jump_over_jr", 32'h800, 1'b1);
        chk_ras("jump_over_jr_ras", 1'b0, 1'b0, 1'b0);
        idle();
        bus.jr = 1; bus.jr_ra = 1; bus.jaddr = 32'h604;
        step();
        chk_pc("jr_pop_after", 32'h604, 1'b1);
        chk_ras("jr_pop_after_ras", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_redirect();
        idle();
        bus.jump = 1; bus.jal = 1; bus.bmemaddr = 32'h900;
        step();
        chk_ras("pre_reset_push", 1'b0, 1'b0, 1'b0);
        idle();
        rst = 1;
        bus.branch = 1; bus.zflag = 1; bus.bmemaddr = 32'h100; bus.bmemload = 32'h20;
        step();
        rst = 0;
        idle();
        chk_pc("reset_wins", 32'h200, 1'b0);
        chk_ras("reset_wins_ras", 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_ras();
        test_jr_empty();
        test_priority();
        test_reset_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
